// File: rtl/bootrom_post_pkg.sv
// Shared postcode type and error-class decode for the boot ROM postcode register.
package bootrom_post_pkg;

   typedef logic [31:0] postcode_t;

   localparam logic [7:0] ERR_CLASS_MIN = 8'hF0;

   function automatic logic is_err_code(input postcode_t code);
      return code[31:24] >= ERR_CLASS_MIN;
   endfunction

endpackage

// File: rtl/bootrom_post_hist_fifo.sv
// Overwrite-oldest circular history of postcodes with a registered read port.
module bootrom_post_hist_fifo
   import bootrom_post_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  postcode_t                  push_data,
   input  logic                       pop,
   input  logic                       clr,
   output postcode_t                  rd_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   postcode_t     mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   postcode_t     rd_data_q;

   logic full;
   logic is_empty;
   logic do_pop;
   logic drop_oldest;
   logic grow;
   logic shrink;

   assign full     = (count_q == FULL_COUNT);
   assign is_empty = (count_q == '0);
   assign do_pop   = pop && !is_empty;
   // A push into a full buffer without a pop pushes the oldest entry out.
   assign drop_oldest = push && full && !do_pop;
   assign grow        = push && !full && !do_pop;
   assign shrink      = do_pop && !push;

   always_ff @(posedge clk) begin
      if (push && !clr && !rst) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop || drop_oldest) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (pop) begin
            rd_data_q <= do_pop ? mem[rd_ptr] : '0;
         end
         if (grow) begin
            count_q <= count_q + CW'(1);
         end else if (shrink) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   assign rd_data = rd_data_q;
   assign count   = count_q;
   assign empty   = is_empty;

endmodule

// File: rtl/bootrom_postcode_reg.sv
// Boot ROM postcode producer: write port, dedup, sticky error/halt, watchdog and history.
module bootrom_postcode_reg
   import bootrom_post_pkg::*;
#(
   parameter int HIST_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int DEDUP          = 1
) (
   input  logic                            Clk,
   input  logic                            Reset,
   input  logic                            WrValid,
   input  logic [31:0]                     WrData,
   output logic                            WrReady,
   output logic [31:0]                     PostCode,
   output logic                            PostStrobe,
   output logic                            ErrorSticky,
   output logic                            Halt,
   output logic                            TimeoutErr,
   input  logic                            HistRdEn,
   output logic [31:0]                     HistRdData,
   output logic [$clog2(HIST_DEPTH+1)-1:0] HistCount,
   output logic                            HistEmpty,
   input  logic                            HistClr
);

   postcode_t post_code_q;
   logic      strobe_q;
   logic      err_q;

   logic accept;
   logic is_repeat;
   logic is_new;

   assign WrReady   = !err_q;
   assign accept    = WrValid && !err_q;
   // A repeat still counts as progress for the watchdog, it just isn't news.
   assign is_repeat = (DEDUP != 0) && (WrData == post_code_q);
   assign is_new    = accept && !is_repeat;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         post_code_q <= '0;
         strobe_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         strobe_q <= is_new;
         if (accept) begin
            post_code_q <= WrData;
         end
         if (accept && is_err_code(WrData)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign PostCode    = post_code_q;
   assign PostStrobe  = strobe_q;
   assign ErrorSticky = err_q;
   assign Halt        = err_q;

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_no_wdog
         assign TimeoutErr = 1'b0;
      end else begin : g_wdog
         localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
         localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

         logic [WW-1:0] wd_cnt;
         logic          timeout_q;

         // Counter freezes once halted or expired; an accept on the last cycle wins.
         always_ff @(posedge Clk) begin
            if (Reset) begin
               wd_cnt    <= '0;
               timeout_q <= 1'b0;
            end else if (!err_q && !timeout_q) begin
               if (accept) begin
                  wd_cnt <= '0;
               end else if (wd_cnt == WD_LAST) begin
                  timeout_q <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + WW'(1);
               end
            end
         end

         assign TimeoutErr = timeout_q;
      end
   endgenerate

   bootrom_post_hist_fifo #(
      .DEPTH(HIST_DEPTH)
   ) u_hist (
      .clk      (Clk),
      .rst      (Reset),
      .push     (is_new),
      .push_data(WrData),
      .pop      (HistRdEn),
      .clr      (HistClr),
      .rd_data  (HistRdData),
      .count    (HistCount),
      .empty    (HistEmpty)
   );

endmodule

// File: tb/tb_bootrom_postcode_reg.sv
// Scoreboard bench for bootrom_postcode_reg against a queue-based reference model.
module tb_bootrom_postcode_reg;

   localparam int HIST_DEPTH     = 8;
   localparam int TIMEOUT_CYCLES = 16;
   localparam int DEDUP          = 1;
   localparam int CW             = $clog2(HIST_DEPTH + 1);

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic          WrValid = 1'b0;
   logic [31:0]   WrData = '0;
   logic          WrReady;
   logic [31:0]   PostCode;
   logic          PostStrobe;
   logic          ErrorSticky;
   logic          Halt;
   logic          TimeoutErr;
   logic          HistRdEn = 1'b0;
   logic [31:0]   HistRdData;
   logic [CW-1:0] HistCount;
   logic          HistEmpty;
   logic          HistClr = 1'b0;

   always #5 Clk = ~Clk;

   bootrom_postcode_reg #(
      .HIST_DEPTH    (HIST_DEPTH),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .DEDUP         (DEDUP)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .WrValid    (WrValid),
      .WrData     (WrData),
      .WrReady    (WrReady),
      .PostCode   (PostCode),
      .PostStrobe (PostStrobe),
      .ErrorSticky(ErrorSticky),
      .Halt       (Halt),
      .TimeoutErr (TimeoutErr),
      .HistRdEn   (HistRdEn),
      .HistRdData (HistRdData),
      .HistCount  (HistCount),
      .HistEmpty  (HistEmpty),
      .HistClr    (HistClr)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_code_q[$];
   logic [31:0] exp_rd_q[$];

   // Reference model state
   logic [31:0] m_code = '0;
   logic        m_err  = 1'b0;
   logic        m_to   = 1'b0;
   int          m_idle = 0;
   logic [31:0] m_hist[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: strobes and history reads are matched against queued expectations
   logic rd_q = 1'b0;
   always @(posedge Clk) rd_q <= HistRdEn && !Reset;

   always @(negedge Clk) begin
      if (PostStrobe === 1'b1) begin
         if (exp_code_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_strobe: got strobe with code %h, expected none", PostCode);
         end else begin
            check("strobe_code", PostCode, exp_code_q.pop_front());
         end
      end
      if (rd_q) begin
         if (exp_rd_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_read: got %h, expected no read", HistRdData);
         end else begin
            check("hist_rd_data", HistRdData, exp_rd_q.pop_front());
         end
      end
   end

   task automatic check_state();
      check("post_code", PostCode, m_code);
      check("wr_ready", {31'd0, WrReady}, {31'd0, !m_err});
      check("error_sticky", {31'd0, ErrorSticky}, {31'd0, m_err});
      check("halt", {31'd0, Halt}, {31'd0, m_err});
      check("timeout_err", {31'd0, TimeoutErr}, {31'd0, m_to});
      check("hist_count", 32'(HistCount), 32'(m_hist.size()));
      check("hist_empty", {31'd0, HistEmpty}, {31'd0, m_hist.size() == 0});
   endtask

   task automatic cycle(input logic wv, input logic [31:0] wd, input logic rd, input logic clr);
      logic acc;
      logic newc;
      WrValid  = wv;
      WrData   = wd;
      HistRdEn = rd;
      HistClr  = clr;
      acc  = wv && !m_err;
      newc = acc && !((DEDUP != 0) && (wd == m_code));
      if (clr) begin
         m_hist.delete();
         if (rd) exp_rd_q.push_back(32'd0);
      end else begin
         if (rd) begin
            if (m_hist.size() == 0) exp_rd_q.push_back(32'd0);
            else exp_rd_q.push_back(m_hist.pop_front());
         end
         if (newc) begin
            m_hist.push_back(wd);
            if (m_hist.size() > HIST_DEPTH) m_hist.delete(0);
         end
      end
      if (newc) exp_code_q.push_back(wd);
      if (!m_err && !m_to) begin
         if (acc) begin
            m_idle = 0;
         end else begin
            m_idle++;
            if (m_idle >= TIMEOUT_CYCLES) m_to = 1'b1;
         end
      end
      if (acc) begin
         m_code = wd;
         if (wd[31:24] >= 8'hF0) m_err = 1'b1;
      end
      @(posedge Clk);
      #1;
      check_state();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      #1;
      check("strobes_drained", 32'(exp_code_q.size()), 32'd0);
      check("reads_drained", 32'(exp_rd_q.size()), 32'd0);
      exp_code_q.delete();
      exp_rd_q.delete();
      Reset    = 1'b1;
      WrValid  = 1'b0;
      WrData   = '0;
      HistRdEn = 1'b0;
      HistClr  = 1'b0;
      @(posedge Clk);
      @(posedge Clk);
      #1;
      Reset  = 1'b0;
      m_code = '0;
      m_err  = 1'b0;
      m_to   = 1'b0;
      m_idle = 0;
      m_hist.delete();
      check_state();
      check("reset_strobe", {31'd0, PostStrobe}, 32'd0);
      check("reset_rd_data", HistRdData, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      logic [31:0] code;
      do_reset();

      // Back-to-back writes, then drain history in order
      for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
      check("four_in_hist", 32'(HistCount), 32'd4);
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);

      // Repeats: one strobe, one history entry
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'd5, 1'b0, 1'b0);
      check("dedup_count", 32'(HistCount), 32'd1);
      idle(10);
      cycle(1'b1, 32'd5, 1'b0, 1'b0);
      idle(10);
      check("dedup_restarts_wdog", {31'd0, TimeoutErr}, 32'd0);

      // Error class halts further writes
      cycle(1'b1, 32'hF100_0002, 1'b0, 1'b0);
      check("err_halt", {31'd0, Halt}, 32'd1);
      check("err_ready", {31'd0, WrReady}, 32'd0);
      cycle(1'b1, 32'd6, 1'b0, 1'b0);
      check("halted_code", PostCode, 32'hF100_0002);
      do_reset();

      // Overflow drops the oldest; ninth pop reads zero
      for (int i = 0; i < 10; i++) cycle(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
      check("full_count", 32'(HistCount), 32'd8);
      for (int i = 0; i < 9; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);
      check("empty_after_pops", 32'(HistCount), 32'd0);

      // Full with push+pop, then clear beats push
      for (int i = 0; i < 8; i++) cycle(1'b1, 32'h20 + 32'(i), 1'b0, 1'b0);
      cycle(1'b1, 32'h28, 1'b1, 1'b0);
      check("full_pushpop", 32'(HistCount), 32'd8);
      cycle(1'b1, 32'h29, 1'b1, 1'b1);
      check("clr_count", 32'(HistCount), 32'd0);
      cycle(1'b0, 32'd0, 1'b1, 1'b0);
      cycle(1'b1, 32'h2A, 1'b1, 1'b0);

      // Watchdog edge
      do_reset();
      idle(TIMEOUT_CYCLES - 1);
      check("wdog_not_yet", {31'd0, TimeoutErr}, 32'd0);
      cycle(1'b1, 32'h77, 1'b0, 1'b0);
      check("wdog_accept_wins", {31'd0, TimeoutErr}, 32'd0);
      idle(TIMEOUT_CYCLES);
      check("wdog_expired", {31'd0, TimeoutErr}, 32'd1);
      cycle(1'b1, 32'h78, 1'b0, 1'b0);
      idle(3);
      check("wdog_sticky", {31'd0, TimeoutErr}, 32'd1);

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if ((m_err || m_to) && $urandom_range(0, 19) == 0) do_reset();
         if ($urandom_range(0, 99) == 0) idle($urandom_range(10, 20));
         code = 32'($urandom_range(0, 12));
         if ($urandom_range(0, 59) == 0) code = {8'hF0 | 8'($urandom_range(0, 15)), 24'($urandom)};
         cycle($urandom_range(0, 99) < 60, code, $urandom_range(0, 99) < 35,
               $urandom_range(0, 99) < 3);
      end

      @(negedge Clk);
      #1;
      check("final_strobes_drained", 32'(exp_code_q.size()), 32'd0);
      check("final_reads_drained", 32'(exp_rd_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
